// File: rtl/dmem_arb_pkg.sv
// Package shared by the data-memory arbiter files.
//   - arb_state_e : arbiter FSM states (IDLE, ACCESS)
//   - BE_BYTE/BE_HALF/BE_WORD : the legal byte-enable patterns
//   - mem_cmd_t   : one latched memory command {wr_en, addr, wr_data, byte_en, id}
//   - cmd_misaligned() : illegal byte-enable / misalignment test, used only when
//     DMEM_ARB_ALIGN_CHECK_EN is defined
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_BE_W   = DMEM_DATA_W / 8;
  // Requester id field, wide enough for the largest legal NUM_REQ (4).
  localparam int DMEM_ID_W   = 2;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                   wr_en;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wr_data;
    logic [DMEM_BE_W-1:0]   byte_en;
    logic [DMEM_ID_W-1:0]   id;
  } mem_cmd_t;

  // True when the byte-enable pattern is not byte/half/word, or when a half
  // or word access is not naturally aligned.
  function automatic logic cmd_misaligned(input logic [3:0] byte_en,
                                          input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b1;
    if (byte_en == BE_BYTE)      bad = 1'b0;
    else if (byte_en == BE_HALF) bad = addr_lo[0];
    else if (byte_en == BE_WORD) bad = (addr_lo != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req        : request vector, one bit per requester
//   last_grant : index of the requester granted most recently (stored by the caller)
//   enable     : when low no grant is issued
//   grant      : one-hot winner, zero when disabled or nothing requested
// The winner is the first requesting index after last_grant, wrapping.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant
);

  logic [IDW-1:0] idx;

  // Walk from the farthest candidate to the nearest one so the nearest
  // requesting index is the last to overwrite the result.
  always_comb begin
    grant = '0;
    idx   = '0;
    if (enable) begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        idx = IDW'((int'(last_grant) + k) % NUM_REQ);
        if (req[idx]) begin
          grant      = '0;
          grant[idx] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port byte-addressed data memory
// between NUM_REQ requesters (req 0 = CPU load/store, req 1 = DMA/loader).
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid_i       per-requester request valid
//   req_ready_o       per-requester accept (one-hot or zero), combinational in IDLE
//   req_wr_en_i       1 = store, 0 = load
//   req_addr_i        byte address
//   req_wr_data_i     store data, LSB-aligned
//   req_byte_en_i     0001 byte, 0011 half, 1111 word
//   resp_valid_o      one-cycle response pulse to the owning requester
//   resp_rd_data_o    load data (0 for stores), valid with resp_valid_o
//   resp_err_o        access rejected (only with DMEM_ARB_ALIGN_CHECK_EN)
//   mem_*_o           memory command; addr/wr_data hold outside ACCESS
//   mem_rd_data_i     combinational memory read data
//   busy_o            FSM is in ACCESS (this is the FSM state, 1 bit)
//
// Handshake: a request transfers at a rising edge where req_valid_i[i] and
// req_ready_o[i] are both high; the requester holds its fields stable and keeps
// valid high until then. Responses cannot be back-pressured.
//
// Timing: handshake at edge N, memory access during cycle N+1, resp_valid in
// cycle N+2. The response cycle is an IDLE cycle, so a new request can be
// accepted while resp_valid is high.
//
// Build option: DMEM_ARB_ALIGN_CHECK_EN rejects illegal byte enables and
// misaligned half/word accesses (no memory enables, rd_data 0, resp_err 1).
// Without it every command is forwarded unchanged and resp_err_o is 0.
//
// ADDR_WIDTH/DATA_WIDTH must match the widths in dmem_arb_pkg.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 2,
  parameter  int ADDR_WIDTH = DMEM_ADDR_W,
  parameter  int DATA_WIDTH = DMEM_DATA_W,
  localparam int BEW        = DATA_WIDTH / 8,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic [NUM_REQ-1:0]                  req_wr_en_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wr_data_i,
  input  logic [NUM_REQ-1:0][BEW-1:0]         req_byte_en_i,
  output logic [NUM_REQ-1:0]                  resp_valid_o,
  output logic [DATA_WIDTH-1:0]               resp_rd_data_o,
  output logic                                resp_err_o,
  output logic [ADDR_WIDTH-1:0]               mem_addr_o,
  output logic                                mem_wr_en_o,
  output logic [DATA_WIDTH-1:0]               mem_wr_data_o,
  output logic [BEW-1:0]                      mem_byte_en_o,
  input  logic [DATA_WIDTH-1:0]               mem_rd_data_i,
  output logic                                busy_o
);

  // Reset value makes requester 0 the first winner.
  localparam logic [IDW-1:0] LAST_GRANT_RST = IDW'(NUM_REQ - 1);

  arb_state_e           state_q, state_d;
  logic [IDW-1:0]       last_grant_q;
  logic [NUM_REQ-1:0]   grant;
  logic [IDW-1:0]       grant_idx;
  mem_cmd_t             cmd_q;
  logic                 reject;
  logic [NUM_REQ-1:0]   resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_data_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_valid_i),
    .last_grant (last_grant_q),
    .enable     (state_q == IDLE),
    .grant      (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = IDW'(i);
    end
  end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign reject = (state_q == ACCESS) && cmd_misaligned(cmd_q.byte_en, cmd_q.addr[1:0]);
`else
  assign reject = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and memory-side outputs
  always_comb begin
    state_d       = state_q;
    req_ready_o   = '0;
    mem_wr_en_o   = 1'b0;
    mem_byte_en_o = '0;
    busy_o        = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        req_ready_o = grant;
        if (|grant) state_d = ACCESS;
      end
      ACCESS: begin
        mem_wr_en_o   = cmd_q.wr_en && !reject;
        mem_byte_en_o = reject ? '0 : cmd_q.byte_en;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address and write data come straight from the latched command, so they
  // hold their last values between accesses.
  assign mem_addr_o    = cmd_q.addr;
  assign mem_wr_data_o = cmd_q.wr_data;

  // Command latch and round-robin pointer, updated on the handshake edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q        <= '0;
      last_grant_q <= LAST_GRANT_RST;
    end else if ((state_q == IDLE) && (|grant)) begin
      cmd_q <= '{wr_en:   req_wr_en_i[grant_idx],
                 addr:    req_addr_i[grant_idx],
                 wr_data: req_wr_data_i[grant_idx],
                 byte_en: req_byte_en_i[grant_idx],
                 id:      DMEM_ID_W'(grant_idx)};
      last_grant_q <= grant_idx;
    end
  end

  // Response register: captured at the end of ACCESS, valid for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= '0;
      if (state_q == ACCESS) begin
        resp_valid_q <= NUM_REQ'(1) << cmd_q.id;
        resp_data_q  <= (cmd_q.wr_en || reject) ? '0 : mem_rd_data_i;
      end
    end
  end

  assign resp_valid_o   = resp_valid_q;
  assign resp_rd_data_o = resp_data_q;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic resp_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  resp_err_q <= 1'b0;
    else if (state_q == ACCESS)  resp_err_q <= reject;
  end
  assign resp_err_o = resp_err_q;
`else
  assign resp_err_o = 1'b0;
`endif

endmodule
